// File: rtl/video_timing_gen_if.sv
// Pixel request / video output bundle for video_timing_gen.
// The generator drives the master side; the pixel source and display sink sit on the slave side.
interface video_timing_gen_if;
    logic        req_en;
    logic [11:0] req_x;
    logic [11:0] req_y;
    logic        o_fs;
    logic [23:0] i_data;
    logic        o_hs;
    logic        o_vs;
    logic        o_de;
    logic [23:0] o_data;

    modport master (
        output req_en, req_x, req_y, o_fs,
        output o_hs, o_vs, o_de, o_data,
        input  i_data
    );

    modport slave (
        input  req_en, req_x, req_y, o_fs,
        input  o_hs, o_vs, o_de, o_data,
        output i_data
    );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: issues pixel requests one stage after the counters and
// presents sync/DE/pixel data two stages after the request, matching a one-cycle source.
module video_timing_gen #(
    parameter logic [11:0] H_ACT  = 12'd1920,
    parameter int          H_FP   = 88,
    parameter int          H_SYNC = 44,
    parameter int          H_BP   = 148,
    parameter logic [11:0] V_ACT  = 12'd1080,
    parameter int          V_FP   = 4,
    parameter int          V_SYNC = 5,
    parameter int          V_BP   = 36,
    parameter bit          HS_POL = 1'b1,
    parameter bit          VS_POL = 1'b1
) (
    input  logic               pclk,
    input  logic               rst_n,
    input  logic               i_en,
    video_timing_gen_if.master vid
);

    localparam logic [11:0] H_SYNC_BEG = 12'(int'(H_ACT) + H_FP);
    localparam logic [11:0] H_SYNC_END = 12'(int'(H_ACT) + H_FP + H_SYNC);
    localparam logic [11:0] H_LAST     = 12'(int'(H_ACT) + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] V_SYNC_BEG = 12'(int'(V_ACT) + V_FP);
    localparam logic [11:0] V_SYNC_END = 12'(int'(V_ACT) + V_FP + V_SYNC);
    localparam logic [11:0] V_LAST     = 12'(int'(V_ACT) + V_FP + V_SYNC + V_BP - 1);

    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic        h_wrap;
    logic        v_wrap;
    logic        hs_raw;
    logic        vs_raw;
    logic        de_raw;

    // Sync levels travel alongside the request so they stay aligned with o_de.
    logic        hs_s1;
    logic        vs_s1;
    logic        de_s2;
    logic        hs_s2;
    logic        vs_s2;

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);
    assign hs_raw = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
    assign vs_raw = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
    assign de_raw = (h_cnt < H_ACT) && (v_cnt < V_ACT);

    // NOTE: every register here uses non-blocking assignment so all stages sample
    // the pre-edge values of their neighbours, whatever order the blocks run in.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (i_en) begin
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_wrap ? 12'd0 : v_cnt + 12'd1;
            end else begin
                h_cnt <= h_cnt + 12'd1;
            end
        end
    end

    // Request stage: idles cleanly while disabled, but sync levels freeze so the
    // display sees the last line/frame state rather than a glitch.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vid.req_en <= 1'b0;
            vid.req_x  <= '0;
            vid.req_y  <= '0;
            vid.o_fs   <= 1'b0;
            hs_s1      <= 1'b0;
            vs_s1      <= 1'b0;
        end else if (i_en) begin
            vid.req_en <= de_raw;
            vid.req_x  <= de_raw ? h_cnt : 12'd0;
            vid.req_y  <= de_raw ? v_cnt : 12'd0;
            vid.o_fs   <= (h_cnt == 12'd0) && (v_cnt == 12'd0);
            hs_s1      <= hs_raw;
            vs_s1      <= vs_raw;
        end else begin
            vid.req_en <= 1'b0;
            vid.req_x  <= '0;
            vid.req_y  <= '0;
            vid.o_fs   <= 1'b0;
        end
    end

    // Stage 2 runs unconditionally so in-flight requests drain while disabled.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            de_s2 <= 1'b0;
            hs_s2 <= 1'b0;
            vs_s2 <= 1'b0;
        end else begin
            de_s2 <= vid.req_en;
            hs_s2 <= hs_s1;
            vs_s2 <= vs_s1;
        end
    end

    // Output stage: i_data arrives during stage 2, so capturing it here lines it up with o_de.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vid.o_de   <= 1'b0;
            vid.o_data <= '0;
            vid.o_hs   <= ~HS_POL;
            vid.o_vs   <= ~VS_POL;
        end else begin
            vid.o_de   <= de_s2;
            vid.o_data <= de_s2 ? vid.i_data : 24'h0;
            vid.o_hs   <= hs_s2 ? HS_POL : ~HS_POL;
            vid.o_vs   <= vs_s2 ? VS_POL : ~VS_POL;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a 16x8 raster: a queue-based reference model feeds a
// per-cycle scoreboard, and scenario tasks check line/frame/enable/reset/polarity behaviour.
module tb_video_timing_gen;

    localparam int H_TOT = 16;
    localparam int V_TOT = 8;

    logic pclk  = 1'b0;
    logic rst_n = 1'b0;
    logic i_en  = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 pclk = ~pclk;

    video_timing_gen_if vid ();
    video_timing_gen_if vid_n ();

    video_timing_gen #(
        .H_ACT(12'd8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACT(12'd4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut (
        .pclk(pclk), .rst_n(rst_n), .i_en(i_en), .vid(vid)
    );

    video_timing_gen #(
        .H_ACT(12'd8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACT(12'd4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut_n (
        .pclk(pclk), .rst_n(rst_n), .i_en(i_en), .vid(vid_n)
    );

    // Pixel source: returns {y,x} one cycle after a request, junk otherwise.
    logic        src_en = 1'b0;
    logic [23:0] src_xy = '0;

    initial forever begin
        @(negedge pclk);
        src_en = vid.req_en;
        src_xy = {vid.req_y, vid.req_x};
    end

    initial forever begin
        @(posedge pclk);
        #1;
        vid.i_data   = src_en ? src_xy : 24'($urandom);
        vid_n.i_data = vid.i_data;
    end

    // Reference model: one request-stage entry per enabled-or-idle clock; outputs pop two edges later.
    typedef struct packed {
        logic        en;
        logic [11:0] x;
        logic [11:0] y;
        logic        fs;
        logic        hs;
        logic        vs;
    } stage_t;

    stage_t pipe_q[$];
    stage_t exp_req = '0;
    stage_t exp_out = '0;
    stage_t nxt;
    int     hm = 0;
    int     vm = 0;
    logic   last_hs = 1'b0;
    logic   last_vs = 1'b0;

    initial forever begin
        @(posedge pclk or negedge rst_n);
        if (!rst_n) begin
            pipe_q.delete();
            hm = 0; vm = 0;
            last_hs = 1'b0; last_vs = 1'b0;
            exp_req = '0; exp_out = '0;
        end else begin
            nxt = '0;
            if (i_en) begin
                nxt.en = (hm < 8) && (vm < 4);
                if (nxt.en) begin
                    nxt.x = 12'(hm);
                    nxt.y = 12'(vm);
                end
                nxt.fs  = (hm == 0) && (vm == 0);
                nxt.hs  = (hm >= 10) && (hm < 13);
                nxt.vs  = (vm >= 5) && (vm < 7);
                last_hs = nxt.hs;
                last_vs = nxt.vs;
                hm++;
                if (hm == H_TOT) begin
                    hm = 0;
                    vm = (vm + 1) % V_TOT;
                end
            end else begin
                nxt.hs = last_hs;
                nxt.vs = last_vs;
            end
            pipe_q.push_back(nxt);
            exp_req = nxt;
            if (pipe_q.size() > 2) exp_out = pipe_q.pop_front();
        end
    end

    // Scoreboard: compare both DUTs against the model every cycle.
    logic [52:0] got_v, exp_v;

    initial forever begin
        @(negedge pclk);
        exp_v = {exp_req.en, exp_req.x, exp_req.y, exp_req.fs, exp_out.en, exp_out.hs, exp_out.vs,
                 exp_out.en ? {exp_out.y, exp_out.x} : 24'h0};
        got_v = {vid.req_en, vid.req_x, vid.req_y, vid.o_fs, vid.o_de, vid.o_hs, vid.o_vs, vid.o_data};
        tests++;
        if (got_v !== exp_v) begin
            fails++;
            $display("FAIL sb_pos t=%0t got=%h exp=%h", $time, got_v, exp_v);
        end
        exp_v[25:24] = ~exp_v[25:24];
        got_v = {vid_n.req_en, vid_n.req_x, vid_n.req_y, vid_n.o_fs, vid_n.o_de, vid_n.o_hs,
                 vid_n.o_vs, vid_n.o_data};
        tests++;
        if (got_v !== exp_v) begin
            fails++;
            $display("FAIL sb_neg t=%0t got=%h exp=%h", $time, got_v, exp_v);
        end
    end

    // Reset, then release with i_en=1; returns in cycle 0, where request (0,0) is visible.
    task automatic start_run();
        @(posedge pclk); #1;
        rst_n = 1'b0;
        i_en  = 1'b0;
        repeat (2) begin @(posedge pclk); #1; end
        rst_n = 1'b1;
        i_en  = 1'b1;
        @(posedge pclk); #1;
    endtask

    task automatic test_reset();
        @(posedge pclk); #1;
        rst_n = 1'b0;
        i_en  = 1'b1;
        repeat (3) begin @(posedge pclk); #1; end
        tests++;
        if ({vid.req_en, vid.req_x, vid.req_y, vid.o_fs, vid.o_de, vid.o_data} !== 51'h0) begin
            fails++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {vid.req_en, vid.req_x, vid.req_y, vid.o_fs, vid.o_de, vid.o_data});
        end
        tests++;
        if ({vid.o_hs, vid.o_vs} !== 2'b00) begin
            fails++;
            $display("FAIL reset_sync_pos got=%b exp=00", {vid.o_hs, vid.o_vs});
        end
        tests++;
        if ({vid_n.o_hs, vid_n.o_vs} !== 2'b11) begin
            fails++;
            $display("FAIL reset_sync_neg got=%b exp=11", {vid_n.o_hs, vid_n.o_vs});
        end
    endtask

    task automatic test_line();
        logic [19:0] req_map, de_map, hs_map;
        logic [19:0] req_exp, de_exp, hs_exp;
        start_run();
        for (int k = 0; k < 20; k++) begin
            req_map[k] = vid.req_en;
            de_map[k]  = vid.o_de;
            hs_map[k]  = vid.o_hs;
            req_exp[k] = (k % 16) < 8;
            de_exp[k]  = (k >= 2) && (((k - 2) % 16) < 8);
            hs_exp[k]  = (k >= 2) && (((k - 2) % 16) >= 10) && (((k - 2) % 16) < 13);
            @(posedge pclk); #1;
        end
        tests++;
        if ($countones(req_map[15:0]) != 8) begin
            fails++;
            $display("FAIL line_req_count got=%0d exp=8", $countones(req_map[15:0]));
        end
        tests++;
        if (req_map !== req_exp) begin
            fails++;
            $display("FAIL line_req_map got=%b exp=%b", req_map, req_exp);
        end
        tests++;
        if (de_map !== de_exp) begin
            fails++;
            $display("FAIL line_de_map got=%b exp=%b", de_map, de_exp);
        end
        tests++;
        if (hs_map !== hs_exp) begin
            fails++;
            $display("FAIL line_hs_map got=%b exp=%b", hs_map, hs_exp);
        end
    endtask

    task automatic test_frame();
        int fs_cnt, vs_cnt, de0, de1, vs_first, data_bad;
        int p, h, v;
        logic [23:0] d_exp;
        fs_cnt = 0; vs_cnt = 0; de0 = 0; de1 = 0; vs_first = -1; data_bad = 0;
        start_run();
        for (int k = 0; k < 264; k++) begin
            if (vid.o_fs) begin
                fs_cnt++;
                tests++;
                if (k % 128 != 0) begin
                    fails++;
                    $display("FAIL frame_fs_pos got=%0d exp=multiple of 128", k);
                end
            end
            if (vid.o_vs && vs_first < 0) vs_first = k;
            if (k >= 2 && k < 130) begin
                vs_cnt += int'(vid.o_vs);
                de0    += int'(vid.o_de);
            end
            if (k >= 130 && k < 258) de1 += int'(vid.o_de);
            p = k - 2;
            h = (p >= 0) ? p % 16 : 0;
            v = (p >= 0) ? (p / 16) % 8 : 0;
            d_exp = (p >= 0 && h < 8 && v < 4) ? {12'(v), 12'(h)} : 24'h0;
            tests++;
            if (vid.o_data !== d_exp) begin
                fails++;
                data_bad++;
                $display("FAIL frame_data k=%0d got=%h exp=%h", k, vid.o_data, d_exp);
            end
            @(posedge pclk); #1;
        end
        tests++;
        if (fs_cnt != 3) begin
            fails++;
            $display("FAIL frame_fs_count got=%0d exp=3", fs_cnt);
        end
        tests++;
        if (vs_cnt != 32 || vs_first != 82) begin
            fails++;
            $display("FAIL frame_vs got=%0d@%0d exp=32@82", vs_cnt, vs_first);
        end
        tests++;
        if (de0 != 32 || de1 != 32) begin
            fails++;
            $display("FAIL frame_de_count got=%0d/%0d exp=32/32", de0, de1);
        end
    endtask

    task automatic test_enable_gap();
        start_run();
        for (int k = 0; k < 28; k++) begin
            if (k >= 19 && k <= 23) begin
                tests++;
                if (vid.req_en !== 1'b0 || vid.o_fs !== 1'b0) begin
                    fails++;
                    $display("FAIL gap_req k=%0d got=%b%b exp=00", k, vid.req_en, vid.o_fs);
                end
            end
            if (k == 19 || k == 20 || k == 26) begin
                tests++;
                if (vid.o_de !== 1'b1) begin
                    fails++;
                    $display("FAIL gap_de_on k=%0d got=%b exp=1", k, vid.o_de);
                end
            end
            if (k >= 21 && k <= 25) begin
                tests++;
                if (vid.o_de !== 1'b0) begin
                    fails++;
                    $display("FAIL gap_de_off k=%0d got=%b exp=0", k, vid.o_de);
                end
            end
            if (k == 24) begin
                tests++;
                if ({vid.req_en, vid.req_y, vid.req_x} !== {1'b1, 12'd1, 12'd3}) begin
                    fails++;
                    $display("FAIL gap_resume got=%b,%0d,%0d exp=1,1,3", vid.req_en, vid.req_y, vid.req_x);
                end
            end
            if (k == 26) begin
                tests++;
                if (vid.o_data !== {12'd1, 12'd3}) begin
                    fails++;
                    $display("FAIL gap_data got=%h exp=%h", vid.o_data, {12'd1, 12'd3});
                end
            end
            if (k == 18) i_en = 1'b0;
            if (k == 23) i_en = 1'b1;
            @(posedge pclk); #1;
        end
    endtask

    task automatic test_mid_reset();
        start_run();
        repeat (36) begin @(posedge pclk); #1; end
        tests++;
        if ({vid.req_en, vid.req_y, vid.req_x, vid.o_de} !== {1'b1, 12'd2, 12'd4, 1'b1}) begin
            fails++;
            $display("FAIL mreset_pre got=%b,%0d,%0d,%b exp=1,2,4,1",
                     vid.req_en, vid.req_y, vid.req_x, vid.o_de);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({vid.req_en, vid.req_x, vid.req_y, vid.o_fs, vid.o_de, vid.o_data, vid.o_hs, vid.o_vs,
             vid_n.o_hs, vid_n.o_vs} !== {53'h0, 2'b11}) begin
            fails++;
            $display("FAIL mreset_async got=%b,%h,%b%b%b%b exp=0,0,0011",
                     vid.req_en, vid.o_data, vid.o_hs, vid.o_vs, vid_n.o_hs, vid_n.o_vs);
        end
        repeat (2) begin @(posedge pclk); #1; end
        rst_n = 1'b1;
        @(posedge pclk); #1;
        tests++;
        if ({vid.req_en, vid.req_x, vid.req_y, vid.o_fs} !== {1'b1, 24'h0, 1'b1}) begin
            fails++;
            $display("FAIL mreset_first got=%b,%0d,%0d,%b exp=1,0,0,1",
                     vid.req_en, vid.req_x, vid.req_y, vid.o_fs);
        end
    endtask

    task automatic test_polarity();
        int hs_lo, vs_lo;
        hs_lo = 0; vs_lo = 0;
        start_run();
        tests++;
        if ({vid_n.o_hs, vid_n.o_vs} !== 2'b11) begin
            fails++;
            $display("FAIL pol_idle got=%b exp=11", {vid_n.o_hs, vid_n.o_vs});
        end
        for (int k = 0; k < 130; k++) begin
            if (k >= 2 && k < 18)  hs_lo += int'(!vid_n.o_hs);
            if (k >= 2 && k < 130) vs_lo += int'(!vid_n.o_vs);
            if (k == 14 || k == 15) begin
                tests++;
                if (vid_n.o_hs !== (k == 15)) begin
                    fails++;
                    $display("FAIL pol_hs_edge k=%0d got=%b exp=%b", k, vid_n.o_hs, k == 15);
                end
            end
            @(posedge pclk); #1;
        end
        tests++;
        if (hs_lo != 3) begin
            fails++;
            $display("FAIL pol_hs_width got=%0d exp=3", hs_lo);
        end
        tests++;
        if (vs_lo != 32) begin
            fails++;
            $display("FAIL pol_vs_width got=%0d exp=32", vs_lo);
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_enable_gap();
        test_mid_reset();
        test_polarity();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
